// File: rtl/mul_share_arb.sv
// NUM_REQ requesters share one 11x11 unsigned multiplier behind a 2-stage pipeline.
// Define MUL_SHARE_ARB_RR_EN for round-robin arbitration; default build is fixed priority (lowest index wins).
module mul_share_arb_mul11 (
  input  logic [10:0] a_i,
  input  logic [10:0] b_i,
  output logic [21:0] p_o
);
  assign p_o = {11'd0, a_i} * {11'd0, b_i};
endmodule

module mul_share_arb #(
  parameter int NUM_REQ = 4
) (
  input  logic                              clk,
  input  logic                              nRST,
  input  logic [NUM_REQ-1:0]                req_valid,
  input  logic [NUM_REQ-1:0][10:0]          req_a,
  input  logic [NUM_REQ-1:0][10:0]          req_b,
  output logic [NUM_REQ-1:0]                req_ready,
  output logic                              rsp_valid,
  input  logic                              rsp_ready,
  output logic [$clog2(NUM_REQ)-1:0]        rsp_id,
  output logic [12:0]                       rsp_result,
  output logic                              rsp_overflow,
  output logic                              rsp_round_loss
);
  localparam int IDW = $clog2(NUM_REQ);

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [10:0]    a;
    logic [10:0]    b;
  } s1_t;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [12:0]    result;
    logic           ovf;
    logic           rloss;
  } s2_t;

  logic           v1_q, v2_q;
  s1_t            s1_q, s1_d;
  s2_t            s2_q, s2_d;
  logic           s1_en, s2_en, xfer, win_vld;
  logic [IDW-1:0] win_id, base;
  logic [21:0]    prod;

  function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] x, input int k);
    int s;
    s = int'(x) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return IDW'(s);
  endfunction

`ifdef MUL_SHARE_ARB_RR_EN
  logic [IDW-1:0] ptr_q, ptr_d;
  assign base  = ptr_q;
  assign ptr_d = xfer ? wrap_add(win_id, 1) : ptr_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end
`else
  assign base = '0;
`endif

  // Scan downward so the lowest offset from base is the last (winning) assignment.
  always_comb begin
    win_vld = 1'b0;
    win_id  = '0;
    for (int k = NUM_REQ-1; k >= 0; k--) begin
      if (req_valid[wrap_add(base, k)]) begin
        win_vld = 1'b1;
        win_id  = wrap_add(base, k);
      end
    end
  end

  assign s2_en     = !v2_q | rsp_ready;
  assign s1_en     = !v1_q | s2_en;
  assign req_ready = (nRST && s1_en && win_vld) ? (NUM_REQ'(1) << win_id) : '0;
  assign xfer      = |(req_valid & req_ready);

  mul_share_arb_mul11 u_mul (
    .a_i (s1_q.a),
    .b_i (s1_q.b),
    .p_o (prod)
  );

  always_comb begin
    s1_d = s1_q;
    if (xfer) begin
      s1_d.id = win_id;
      s1_d.a  = req_a[win_id];
      s1_d.b  = req_b[win_id];
    end
  end

  always_comb begin
    s2_d = s2_q;
    if (v1_q) begin
      s2_d.id     = s1_q.id;
      s2_d.result = prod[20:8];
      s2_d.ovf    = prod[21];
      s2_d.rloss  = |prod[7:0];
    end
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      v1_q <= 1'b0;
      v2_q <= 1'b0;
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      if (s1_en) begin
        v1_q <= xfer;
        s1_q <= s1_d;
      end
      if (s2_en) begin
        v2_q <= v1_q;
        s2_q <= s2_d;
      end
    end
  end

  assign rsp_valid      = v2_q;
  assign rsp_id         = s2_q.id;
  assign rsp_result     = s2_q.result;
  assign rsp_overflow   = s2_q.ovf;
  assign rsp_round_loss = s2_q.rloss;
endmodule

// File: doc/mul_share_arb.md
MUL_SHARE_ARB -- requirements
Module: mul_share_arb

Interface
REQ-001 The block SHALL have one clock and an asynchronous active-low reset; ports are named clk and nRST.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (legal range 2..8).
REQ-003 clk  in  1  rising-edge clock.
REQ-004 nRST  in  1  asynchronous active-low reset.
REQ-005 req_valid  in  NUM_REQ  per-requester operand valid.
REQ-006 req_a, req_b  in  NUM_REQ x 11  per-requester operands.
REQ-007 req_ready  out  NUM_REQ  one-hot grant; a transfer happens when req_valid[i] and req_ready[i] are both high.
REQ-008 rsp_valid  out  1  response valid.
REQ-009 rsp_ready  in  1  downstream accepts the response.
REQ-010 rsp_id  out  clog2(NUM_REQ)  index of the requester that owns the response.
REQ-011 rsp_result  out  13  product bits [20:8].
REQ-012 rsp_overflow, rsp_round_loss  out  1 each  product bit 21, and OR of product bits [7:0].

Function
REQ-013 The block SHALL contain one instance of the shared 11x11 combinational multiplier, with a 2-stage pipeline around it: S1 operand register (v1, id1, a1, b1) and S2 result register (v2, id2, result, flags).
REQ-014 Product semantics SHALL be an unsigned 22-bit a*b: result = P[20:8], overflow = P[21], round_loss = |P[7:0].
REQ-015 Stall rule: s2_en = !v2 | rsp_ready; s1_en = !v1 | s2_en.
REQ-016 req_ready SHALL be all-zero when s1_en is low; otherwise it SHALL be one-hot on the arbitration winner among asserted req_valid bits, or all-zero if none are asserted.
REQ-017 req_ready SHALL be purely combinational from req_valid, pointer and pipeline state; it SHALL NOT depend on req_a/req_b.
REQ-018 On s1_en: v1 <= |(req_valid & req_ready); a1/b1/id1 SHALL be loaded only when a transfer occurs.
REQ-019 On s2_en: v2 <= v1; result/flags/id2 SHALL be loaded from the multiplier output of a1/b1 when v1 is high.
REQ-020 rsp_* SHALL be driven directly from S2; rsp_valid = v2.
REQ-021 Latency SHALL be 2 cycles: an accepted transfer in cycle N gives rsp_valid in cycle N+2 if no stall occurs.
REQ-022 Throughput SHALL be one transfer per cycle while rsp_ready is held high.
REQ-023 While rsp_valid is high and rsp_ready is low, all rsp_* outputs SHALL hold stable.
REQ-024 Backpressure SHALL lose no data: with both stages full and rsp_ready low, req_ready is all-zero.
REQ-025 A simultaneous response accept and new grant in the same cycle SHALL be allowed, and the pipeline SHALL advance by one.
REQ-026 Responses SHALL leave in grant order; no reordering.
REQ-027 Arbitration pointer ptr (clog2(NUM_REQ) bits): after a transfer by requester i, ptr <= (i+1) mod NUM_REQ, wrapping from NUM_REQ-1 to 0.
REQ-028 ptr SHALL be unchanged in cycles without a transfer.

Reset
REQ-029 Asserting nRST low SHALL asynchronously clear v1, v2, ptr, and the a1, b1, id1, id2, result and flags registers to 0.
REQ-030 During reset, rsp_valid = 0, rsp_id = 0, rsp_result = 0, rsp_overflow = 0, rsp_round_loss = 0 and req_ready = all-zero.
REQ-031 Reset mid-operation SHALL discard in-flight operations without emitting a response.
REQ-032 The first grant SHALL be possible in the first rising edge after nRST deasserts.

Configuration
REQ-033 Macro MUL_SHARE_ARB_RR_EN SHALL select the arbitration policy.
REQ-034 With MUL_SHARE_ARB_RR_EN defined: round-robin; the winner is the first asserted req_valid at or after ptr, scanning upward and wrapping.
REQ-035 Without MUL_SHARE_ARB_RR_EN: fixed priority, lowest index wins; ptr logic is removed and pipeline behaviour is otherwise identical.

Verification
REQ-036 Single request: requester 2 sends a=11'h400, b=11'h400 with rsp_ready=1 -> two cycles later rsp_valid=1, rsp_id=2, rsp_result=13'h1000, rsp_overflow=0, rsp_round_loss=0.
REQ-037 Max operands: a=b=11'h7FF -> rsp_result=13'h1FF0, rsp_overflow=1, rsp_round_loss=1.
REQ-038 RR fairness (RR_EN): all 4 req_valid held high for 8 cycles with rsp_ready=1 -> grant sequence 0,1,2,3,0,1,2,3 and rsp_id follows the same order delayed by 2. Without RR_EN -> requester 0 is granted every cycle.
REQ-039 Backpressure: rsp_ready=0 with continuous requests -> exactly 2 transfers accepted, then req_ready=0 and rsp_* stable. Releasing rsp_ready -> 1 response per cycle in grant order, no loss or duplication.
REQ-040 Reset mid-flight: nRST pulsed low with v1=v2=1 -> rsp_valid=0 immediately and after release, with no stale response. A new request after release completes in 2 cycles with ptr restarted at 0.
